// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU op codes, register zero, widths
// and the control bundle carried through the ID/EX register.
package mips_pkg;

   localparam int DW = 32;
   localparam int RW = 5;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_OR   = 3'b010;
   localparam logic [2:0] ALU_SLT  = 3'b011;
   localparam logic [2:0] ALU_SLTU = 3'b100;

   localparam logic [RW-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic ovf_en;
   } ex_ctrl_t;

   localparam ex_ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// Operand forward mux: EX/MEM result beats MEM/WB result beats the
// registered value; register zero is never forwarded.
module fwd_sel
   import mips_pkg::*;
#(
   parameter int DW = mips_pkg::DW,
   parameter int RW = mips_pkg::RW,
   parameter bit EN = 1'b1
) (
   input  logic [RW-1:0] idx,
   input  logic [DW-1:0] reg_val,
   input  logic          exm_reg_write,
   input  logic [RW-1:0] exm_rd,
   input  logic [DW-1:0] exm_result,
   input  logic          mwb_reg_write,
   input  logic [RW-1:0] mwb_rd,
   input  logic [DW-1:0] mwb_result,
   output logic [DW-1:0] fwd_val
);

   always_comb begin
      fwd_val = reg_val;
      if (EN && idx != REG_ZERO[RW-1:0]) begin
         if (exm_reg_write && exm_rd == idx)
            fwd_val = exm_result;
         else if (mwb_reg_write && mwb_rd == idx)
            fwd_val = mwb_result;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and RAW hazard detect.
// FWD_EN: forward EX/MEM and MEM/WB results; otherwise stall on any RAW.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DW = mips_pkg::DW,
   parameter int RW = mips_pkg::RW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,
   input  logic          flush,
   input  logic          id_valid,
   input  logic [DW-1:0] id_pc,
   input  logic [DW-1:0] id_rs_val,
   input  logic [DW-1:0] id_rt_val,
   input  logic [DW-1:0] id_imm,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic [RW-1:0] id_rd,
   input  logic [2:0]    id_alu_op,
   input  logic          id_alu_src,
   input  logic          id_reg_write,
   input  logic          id_mem_read,
   input  logic          id_mem_write,
   input  logic          id_ovf_en,
   input  logic          exm_reg_write,
   input  logic [RW-1:0] exm_rd,
   input  logic [DW-1:0] exm_result,
   input  logic          mwb_reg_write,
   input  logic [RW-1:0] mwb_rd,
   input  logic [DW-1:0] mwb_result,
   output logic          hazard,
   output logic          ex_valid,
   output logic [DW-1:0] ex_pc,
   output logic [DW-1:0] ex_data1,
   output logic [DW-1:0] ex_data2,
   output logic [DW-1:0] ex_store_data,
   output logic [2:0]    ex_alu_op,
   output logic [RW-1:0] ex_rd,
   output logic          ex_reg_write,
   output logic          ex_mem_read,
   output logic          ex_mem_write,
   output logic          ex_ovf_en
);

`ifdef FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic          valid_q;
   logic [DW-1:0] pc_q;
   logic [DW-1:0] rs_val_q;
   logic [DW-1:0] rt_val_q;
   logic [DW-1:0] imm_q;
   logic [RW-1:0] rs_q;
   logic [RW-1:0] rt_q;
   logic [RW-1:0] rd_q;
   logic [2:0]    op_q;
   logic          src_q;
   ex_ctrl_t      ctrl_q;
   ex_ctrl_t      id_ctrl;
   logic [DW-1:0] fwd_rs;
   logic [DW-1:0] fwd_rt;
   logic          raw;

   function automatic logic dep(
      input logic          en,
      input logic [RW-1:0] rd,
      input logic [RW-1:0] rs,
      input logic [RW-1:0] rt
   );
      return en && rd != REG_ZERO[RW-1:0] && (rd == rs || rd == rt);
   endfunction

   assign id_ctrl = '{
      reg_write: id_reg_write,
      mem_read:  id_mem_read,
      mem_write: id_mem_write,
      ovf_en:    id_ovf_en
   };

`ifdef FWD_EN
   assign raw = dep(valid_q && ctrl_q.mem_read, rd_q, id_rs, id_rt);
`else
   assign raw = dep(valid_q && ctrl_q.reg_write, rd_q, id_rs, id_rt)
             || dep(exm_reg_write, exm_rd, id_rs, id_rt)
             || dep(mwb_reg_write, mwb_rd, id_rs, id_rt);
`endif

   // A stalled ID cannot act on a hold request, so suppress it.
   assign hazard = id_valid && !stall && raw;

   always_ff @(posedge clk) begin
      if (rst || flush || (!stall && hazard)) begin
         valid_q  <= 1'b0;
         pc_q     <= '0;
         rs_val_q <= '0;
         rt_val_q <= '0;
         imm_q    <= '0;
         rs_q     <= '0;
         rt_q     <= '0;
         rd_q     <= '0;
         op_q     <= '0;
         src_q    <= 1'b0;
         ctrl_q   <= CTRL_NONE;
      end else if (!stall) begin
         valid_q  <= id_valid;
         pc_q     <= id_pc;
         rs_val_q <= id_rs_val;
         rt_val_q <= id_rt_val;
         imm_q    <= id_imm;
         rs_q     <= id_rs;
         rt_q     <= id_rt;
         rd_q     <= id_rd;
         op_q     <= id_alu_op;
         src_q    <= id_alu_src;
         ctrl_q   <= id_valid ? id_ctrl : CTRL_NONE;
      end
   end

   fwd_sel #(.DW(DW), .RW(RW), .EN(FWD)) u_fwd_rs (
      .idx           (rs_q),
      .reg_val       (rs_val_q),
      .exm_reg_write (exm_reg_write),
      .exm_rd        (exm_rd),
      .exm_result    (exm_result),
      .mwb_reg_write (mwb_reg_write),
      .mwb_rd        (mwb_rd),
      .mwb_result    (mwb_result),
      .fwd_val       (fwd_rs)
   );

   fwd_sel #(.DW(DW), .RW(RW), .EN(FWD)) u_fwd_rt (
      .idx           (rt_q),
      .reg_val       (rt_val_q),
      .exm_reg_write (exm_reg_write),
      .exm_rd        (exm_rd),
      .exm_result    (exm_result),
      .mwb_reg_write (mwb_reg_write),
      .mwb_rd        (mwb_rd),
      .mwb_result    (mwb_result),
      .fwd_val       (fwd_rt)
   );

   assign ex_valid      = valid_q;
   assign ex_pc         = pc_q;
   assign ex_data1      = fwd_rs;
   assign ex_data2      = src_q ? imm_q : fwd_rt;
   assign ex_store_data = fwd_rt;
   assign ex_alu_op     = op_q;
   assign ex_rd         = rd_q;
   assign ex_reg_write  = valid_q && ctrl_q.reg_write;
   assign ex_mem_read   = valid_q && ctrl_q.mem_read;
   assign ex_mem_write  = valid_q && ctrl_q.mem_write;
   assign ex_ovf_en     = valid_q && ctrl_q.ovf_en;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage; works with FWD_EN defined or not.
module tb_id_ex_stage;
   import mips_pkg::*;

`ifdef FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, stall, flush, id_valid;
   logic [31:0] id_pc, id_rs_val, id_rt_val, id_imm;
   logic [4:0] id_rs, id_rt, id_rd;
   logic [2:0] id_alu_op;
   logic id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_ovf_en;
   logic exm_reg_write, mwb_reg_write;
   logic [4:0] exm_rd, mwb_rd;
   logic [31:0] exm_result, mwb_result;
   logic hazard, ex_valid;
   logic [31:0] ex_pc, ex_data1, ex_data2, ex_store_data;
   logic [2:0] ex_alu_op;
   logic [4:0] ex_rd;
   logic ex_reg_write, ex_mem_read, ex_mem_write, ex_ovf_en;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_on = 1'b0;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_pc(id_pc),
      .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_ovf_en(id_ovf_en),
      .exm_reg_write(exm_reg_write), .exm_rd(exm_rd),
      .exm_result(exm_result),
      .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd),
      .mwb_result(mwb_result),
      .hazard(hazard), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_data1(ex_data1), .ex_data2(ex_data2),
      .ex_store_data(ex_store_data), .ex_alu_op(ex_alu_op),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_ovf_en(ex_ovf_en)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: what instruction the stage currently holds.
   bit m_valid = 0;
   logic [31:0] m_pc = 0, m_rsv = 0, m_rtv = 0, m_imm = 0;
   logic [4:0] m_rs = 0, m_rt = 0, m_rd = 0;
   logic [2:0] m_op = 0;
   bit m_src = 0, m_rw = 0, m_mr = 0, m_mw = 0, m_ovf = 0;

   function automatic bit reads(input logic [4:0] r);
      return r != 0 && (r == id_rs || r == id_rt);
   endfunction

   function automatic bit exp_hazard();
      if (stall || !id_valid) return 0;
      if (FWD) return m_valid && m_mr && reads(m_rd);
      return (m_valid && m_rw && reads(m_rd))
          || (exm_reg_write && reads(exm_rd))
          || (mwb_reg_write && reads(mwb_rd));
   endfunction

   function automatic logic [31:0] src_val(input logic [4:0] r,
                                          input logic [31:0] v);
      if (!FWD || r == 0) return v;
      if (exm_reg_write && exm_rd == r) return exm_result;
      if (mwb_reg_write && mwb_rd == r) return mwb_result;
      return v;
   endfunction

   always @(posedge clk) begin
      automatic bit h = exp_hazard();
      if (rst || flush || (!stall && h)) begin
         m_valid = 0;
         {m_rw, m_mr, m_mw, m_ovf} = 4'b0;
      end else if (!stall) begin
         m_valid = id_valid;
         m_pc = id_pc; m_rsv = id_rs_val; m_rtv = id_rt_val;
         m_imm = id_imm; m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
         m_op = id_alu_op; m_src = id_alu_src;
         m_rw = id_valid && id_reg_write;
         m_mr = id_valid && id_mem_read;
         m_mw = id_valid && id_mem_write;
         m_ovf = id_valid && id_ovf_en;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("m_hazard", 32'(hazard), 32'(exp_hazard()));
         chk("m_valid", 32'(ex_valid), 32'(m_valid));
         chk("m_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write,
             ex_ovf_en}), 32'({m_rw, m_mr, m_mw, m_ovf}));
         if (m_valid) begin
            chk("m_pc", ex_pc, m_pc);
            chk("m_rd", 32'(ex_rd), 32'(m_rd));
            chk("m_op", 32'(ex_alu_op), 32'(m_op));
            chk("m_data1", ex_data1, src_val(m_rs, m_rsv));
            chk("m_data2", ex_data2,
                m_src ? m_imm : src_val(m_rt, m_rtv));
            chk("m_store", ex_store_data, src_val(m_rt, m_rtv));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic instr(input logic [31:0] pc, input logic [4:0] rs,
         input logic [4:0] rt, input logic [4:0] rd,
         input logic [31:0] rsv, input logic [31:0] rtv,
         input logic [31:0] imm, input logic [2:0] op,
         input bit src, input bit rw, input bit mr,
         input bit mw, input bit ovf);
      id_valid = 1; id_pc = pc; id_rs = rs; id_rt = rt; id_rd = rd;
      id_rs_val = rsv; id_rt_val = rtv; id_imm = imm; id_alu_op = op;
      id_alu_src = src; id_reg_write = rw; id_mem_read = mr;
      id_mem_write = mw; id_ovf_en = ovf;
   endtask

   task automatic clr_wb();
      exm_reg_write = 0; exm_rd = 0; exm_result = 0;
      mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0;
   endtask

   initial begin
      rst = 1; stall = 0; flush = 0;
      instr(32'h4, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'h0,
            ALU_ADD, 0, 1, 0, 0, 0);
      clr_wb();
      // reset held for two edges with a live ID instruction
      cyc();
      chk_on = 1;
      cyc();
      settle();
      chk("rst_valid", 32'(ex_valid), 32'd0);
      chk("rst_regwr", 32'(ex_reg_write), 32'd0);
      chk("rst_data1", ex_data1, 32'd0);
      chk("rst_hazard", 32'(hazard), 32'd0);
      rst = 0;

      // add r3=r1+r2, then sub r4=r3-r1
      instr(32'h10, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h0,
            ALU_ADD, 0, 1, 0, 0, 1);
      cyc();
      instr(32'h14, 5'd3, 5'd1, 5'd4, 32'h300, 32'h100, 32'h0,
            ALU_SUB, 0, 1, 0, 0, 1);
      settle();
      chk("sub_raw_hazard", 32'(hazard), FWD ? 32'd0 : 32'd1);
      cyc();
      cyc();
      id_valid = 0;
      exm_reg_write = 1; exm_rd = 3; exm_result = 32'h10;
      mwb_reg_write = 1; mwb_rd = 3; mwb_result = 32'h20;
      settle();
      chk("fwd_exm_wins", ex_data1, FWD ? 32'h10 : 32'h300);
      chk("fwd_rt_nomatch", ex_data2, 32'h100);
      chk("sub_op", 32'(ex_alu_op), 32'(ALU_SUB));
      exm_reg_write = 0;
      settle();
      chk("fwd_mwb", ex_data1, FWD ? 32'h20 : 32'h300);
      cyc();
      clr_wb();

      // lw r5 followed by a user of r5
      instr(32'h20, 5'd1, 5'd5, 5'd5, 32'h1000, 32'h0, 32'h4,
            ALU_ADD, 1, 1, 1, 0, 0);
      cyc();
      chk("lw_mem_read", 32'(ex_mem_read), 32'd1);
      chk("lw_data2_imm", ex_data2, 32'h4);
      instr(32'h24, 5'd6, 5'd5, 5'd7, 32'h66, 32'h55, 32'h0,
            ALU_OR, 0, 1, 0, 0, 0);
      settle();
      chk("lu_hazard", 32'(hazard), 32'd1);
      cyc();
      chk("lu_bubble", 32'(ex_valid), 32'd0);
      chk("lu_bubble_wr", 32'(ex_reg_write), 32'd0);
      chk("lu_hazard_gone", 32'(hazard), 32'd0);
      cyc();
      chk("lu_load_valid", 32'(ex_valid), 32'd1);
      chk("lu_load_rd", 32'(ex_rd), 32'd7);
      chk("lu_load_d1", ex_data1, 32'h66);

      // register zero is never forwarded
      instr(32'h28, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 32'h0,
            ALU_ADD, 0, 1, 0, 0, 0);
      exm_reg_write = 1; exm_rd = 0; exm_result = 32'hDEAD;
      mwb_reg_write = 1; mwb_rd = 0; mwb_result = 32'hBEEF;
      settle();
      chk("r0_no_hazard", 32'(hazard), 32'd0);
      cyc();
      chk("r0_data1", ex_data1, 32'd0);
      chk("r0_data2", ex_data2, 32'd0);
      clr_wb();

      // stall holds, suppresses hazard; flush beats stall
      instr(32'h40, 5'd1, 5'd9, 5'd9, 32'h11, 32'h0, 32'h8,
            ALU_ADD, 1, 1, 1, 0, 0);
      cyc();
      stall = 1;
      instr(32'h44, 5'd9, 5'd2, 5'd10, 32'h22, 32'h33, 32'h0,
            ALU_SLT, 0, 1, 0, 1, 1);
      settle();
      chk("stall_no_hazard", 32'(hazard), 32'd0);
      for (int i = 0; i < 3; i++) begin
         id_pc = 32'h44 + 32'(i) * 4;
         id_rs_val = 32'h100 + 32'(i);
         cyc();
      end
      chk("stall_pc", ex_pc, 32'h40);
      chk("stall_rd", 32'(ex_rd), 32'd9);
      chk("stall_mr", 32'(ex_mem_read), 32'd1);
      flush = 1;
      cyc();
      chk("flush_stall_valid", 32'(ex_valid), 32'd0);
      chk("flush_stall_mr", 32'(ex_mem_read), 32'd0);
      flush = 0; stall = 0;

      // flush and hazard together
      instr(32'h50, 5'd1, 5'd9, 5'd9, 32'h0, 32'h0, 32'h0,
            ALU_ADD, 1, 1, 1, 0, 0);
      cyc();
      instr(32'h54, 5'd9, 5'd3, 5'd12, 32'h0, 32'h0, 32'h0,
            ALU_ADD, 0, 1, 0, 0, 0);
      flush = 1;
      settle();
      chk("flush_hazard_rep", 32'(hazard), 32'd1);
      cyc();
      chk("flush_hazard_valid", 32'(ex_valid), 32'd0);
      flush = 0;

      // reset while stalled
      instr(32'h60, 5'd2, 5'd3, 5'd11, 32'h7, 32'h8, 32'h0,
            ALU_SLTU, 0, 0, 0, 1, 0);
      cyc();
      chk("st_mem_write", 32'(ex_mem_write), 32'd1);
      stall = 1; rst = 1;
      cyc();
      chk("rst_stall_valid", 32'(ex_valid), 32'd0);
      chk("rst_stall_pc", ex_pc, 32'd0);
      chk("rst_stall_mw", 32'(ex_mem_write), 32'd0);
      rst = 0; stall = 0;
      id_valid = 0;
      cyc();

      // producer still in EX/MEM, then in MEM/WB
      instr(32'h70, 5'd7, 5'd0, 5'd12, 32'h77, 32'h0, 32'h0,
            ALU_ADD, 0, 1, 0, 0, 0);
      exm_reg_write = 1; exm_rd = 7; exm_result = 32'h1234;
      settle();
      chk("exm_raw_hazard", 32'(hazard), FWD ? 32'd0 : 32'd1);
      cyc();
      chk("exm_raw_valid", 32'(ex_valid), FWD ? 32'd1 : 32'd0);
      chk("exm_raw_data1", ex_data1, FWD ? 32'h1234 : 32'd0);
      exm_reg_write = 0;
      mwb_reg_write = 1; mwb_rd = 7; mwb_result = 32'h4321;
      settle();
      chk("mwb_raw_hazard", 32'(hazard), FWD ? 32'd0 : 32'd1);
      mwb_reg_write = 0;
      settle();
      chk("retired_hazard", 32'(hazard), 32'd0);
      cyc();
      chk("retired_valid", 32'(ex_valid), 32'd1);
      chk("retired_data1", ex_data1, 32'h77);
      id_valid = 0;
      clr_wb();
      cyc();
      cyc();
      chk_on = 0;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
